// File: rtl/obstacle_scheduler.sv
// rtl/obstacle_scheduler.sv - frame-rate obstacle/scroll sequencer and IDLE/RUN/HIT/OVER game FSM
// Optional feature macro: SCHED_SPEEDUP_EN (scroll step grows with score, capped at 2*SCROLL_STEP)
module obstacle_scheduler #(
  parameter int SCROLL_STEP     = 2,
  parameter int SPAWN_GAP       = 160,
  parameter int SCREEN_W        = 640,
  parameter logic [7:0] LFSR_SEED = 8'hA5,
  parameter int HIT_FRAMES      = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       collision,
  output logic [9:0] x_offset,
  output logic [9:0] obs_x,
  output logic [9:0] obs_y,
  output logic       obs_kind,
  output logic       obs_valid,
  output logic       show_player,
  output logic [3:0] sin_pos,
  output logic [7:0] score,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  gap_cnt;
  logic        hit_flag;
  logic [7:0]  hit_cnt;
  logic [7:0]  lfsr;
  logic [1:0]  tick_div;

  logic [4:0]  step;
  logic        hit_now;
  logic        hit_last;
  logic [10:0] x_sum;
  logic [9:0]  x_wrap;
  logic [9:0]  gap_sum;
  logic [7:0]  hit_cnt_inc;
  logic [7:0]  lfsr_next;

`ifdef SCHED_SPEEDUP_EN
  logic [4:0] boost_sum;
  assign boost_sum = 5'(SCROLL_STEP) + {1'b0, score[7:4]};
  assign step      = (boost_sum > 5'(2 * SCROLL_STEP)) ? 5'(2 * SCROLL_STEP) : boost_sum;
`else
  assign step = 5'(SCROLL_STEP);
`endif

  // A collision on the tick cycle itself still belongs to the frame that is ending
  assign hit_now     = hit_flag | collision;
  assign hit_last    = (hit_cnt == 8'(HIT_FRAMES - 1));
  assign x_sum       = {1'b0, x_offset} + 11'(step);
  assign x_wrap      = (x_sum >= 11'(SCREEN_W)) ? 10'(x_sum - 11'(SCREEN_W)) : x_sum[9:0];
  assign gap_sum     = gap_cnt + 10'(step);
  assign hit_cnt_inc = hit_cnt + 8'd1;
  assign lfsr_next   = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  assign state       = state_q;

  // Game state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state selection: start from IDLE/OVER, hit on a RUN tick, timeout out of HIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (frame_tick && hit_now) state_d = HIT;
      HIT:     if (frame_tick && hit_last) state_d = OVER;
      OVER:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Per-frame datapath: scroll, obstacle slot, score, phase, hit timing and LFSR
  always_ff @(posedge clk) begin
    if (rst) begin
      x_offset    <= '0;
      obs_x       <= '0;
      obs_y       <= '0;
      obs_kind    <= 1'b0;
      obs_valid   <= 1'b0;
      show_player <= 1'b1;
      sin_pos     <= '0;
      score       <= '0;
      gap_cnt     <= '0;
      hit_flag    <= 1'b0;
      hit_cnt     <= '0;
      tick_div    <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next;
      case (state_q)
        IDLE, OVER: begin
          // Restart: a tick in the same cycle does not scroll
          if (start) begin
            x_offset  <= '0;
            obs_valid <= 1'b0;
            score     <= '0;
            gap_cnt   <= '0;
            sin_pos   <= '0;
            tick_div  <= '0;
            hit_flag  <= 1'b0;
          end
        end
        RUN: begin
          if (collision) hit_flag <= 1'b1;
          if (frame_tick) begin
            x_offset <= x_wrap;
            if (obs_valid && (obs_x < 10'(step))) begin
              obs_valid <= 1'b0;
              gap_cnt   <= '0;
              if (score != 8'hFF) score <= score + 8'd1;
            end else if (obs_valid) begin
              obs_x <= obs_x - 10'(step);
            end else if (gap_sum >= 10'(SPAWN_GAP)) begin
              obs_valid <= 1'b1;
              obs_x     <= 10'(SCREEN_W - 1);
              obs_kind  <= lfsr[0];
              obs_y     <= 10'd120 + {2'b00, lfsr[6:1], 2'b00};
              gap_cnt   <= '0;
            end else begin
              gap_cnt <= gap_sum;
            end
            tick_div <= tick_div + 2'd1;
            if (tick_div == 2'd3) sin_pos <= sin_pos + 4'd1;
            if (hit_now) begin
              hit_flag    <= 1'b0;
              hit_cnt     <= '0;
              show_player <= 1'b1;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (hit_last) begin
              show_player <= 1'b1;
            end else begin
              hit_cnt     <= hit_cnt_inc;
              show_player <= ~hit_cnt_inc[3];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb/tb_obstacle_scheduler.sv - directed self-checking bench for obstacle_scheduler
module tb_obstacle_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       start;
  logic       collision;
  logic [9:0] x_offset;
  logic [9:0] obs_x;
  logic [9:0] obs_y;
  logic       obs_kind;
  logic       obs_valid;
  logic       show_player;
  logic [3:0] sin_pos;
  logic [7:0] score;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  obstacle_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .start       (start),
    .collision   (collision),
    .x_offset    (x_offset),
    .obs_x       (obs_x),
    .obs_y       (obs_y),
    .obs_kind    (obs_kind),
    .obs_valid   (obs_valid),
    .show_player (show_player),
    .sin_pos     (sin_pos),
    .score       (score),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One frame: tick pulse then idle cycles; returns on a falling edge
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; start = 1'b0; collision = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    chk("rst_state",  32'(state), 0);
    chk("rst_xoff",   32'(x_offset), 0);
    chk("rst_obs_x",  32'(obs_x), 0);
    chk("rst_obs_y",  32'(obs_y), 0);
    chk("rst_kind",   32'(obs_kind), 0);
    chk("rst_valid",  32'(obs_valid), 0);
    chk("rst_show",   32'(show_player), 1);
    chk("rst_sin",    32'(sin_pos), 0);
    chk("rst_score",  32'(score), 0);

    ticks(3);
    chk("idle_state", 32'(state), 0);
    chk("idle_xoff",  32'(x_offset), 0);
    chk("idle_valid", 32'(obs_valid), 0);

    @(negedge clk) collision = 1'b1;
    @(negedge clk) collision = 1'b0;
    chk("idle_coll_state", 32'(state), 0);

    // Start coincident with a tick: enters RUN without scrolling
    @(negedge clk) begin start = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin start = 1'b0; frame_tick = 1'b0; end
    chk("start_state", 32'(state), 1);
    chk("start_xoff",  32'(x_offset), 0);
    @(negedge clk);

    ticks(4);
    chk("sin_after4", 32'(sin_pos), 1);
    ticks(75);
    chk("t79_valid", 32'(obs_valid), 0);
    chk("t79_xoff",  32'(x_offset), 158);
    chk("t79_state", 32'(state), 1);
    tick();
    chk("t80_valid", 32'(obs_valid), 1);
    chk("t80_obs_x", 32'(obs_x), 639);
    chk("t80_obs_y_range", 32'((obs_y >= 10'd120) && (obs_y <= 10'd372) && (obs_y[1:0] == 2'b00)), 1);
    chk("t80_xoff",  32'(x_offset), 160);
    chk("t80_sin",   32'(sin_pos), 4);

    ticks(240);
    chk("t320_xoff",  32'(x_offset), 0);
    chk("t320_obs_x", 32'(obs_x), 159);

    ticks(79);
    chk("t399_obs_x", 32'(obs_x), 1);
    chk("t399_score", 32'(score), 0);
    tick();
    chk("t400_valid", 32'(obs_valid), 0);
    chk("t400_score", 32'(score), 1);
    ticks(79);
    chk("t479_valid", 32'(obs_valid), 0);
    tick();
    chk("t480_valid", 32'(obs_valid), 1);
    chk("t480_obs_x", 32'(obs_x), 639);
    chk("t480_score", 32'(score), 1);

    // Mid-frame collision latches, takes effect at the next tick
    @(negedge clk) collision = 1'b1;
    @(negedge clk) collision = 1'b0;
    chk("coll_pending_state", 32'(state), 1);
    tick();
    chk("hit_state", 32'(state), 2);
    chk("hit_obs_x", 32'(obs_x), 637);
    chk("hit_xoff",  32'(x_offset), 322);
    chk("hit_show",  32'(show_player), 1);

    ticks(7);
    chk("hit7_show", 32'(show_player), 1);
    tick();
    chk("hit8_show", 32'(show_player), 0);
    pulse_start();
    chk("hit_start_ignored", 32'(state), 2);
    ticks(8);
    chk("hit16_show", 32'(show_player), 1);
    ticks(43);
    chk("hit59_state", 32'(state), 2);
    chk("hit59_obs_x", 32'(obs_x), 637);
    chk("hit59_xoff",  32'(x_offset), 322);
    tick();
    chk("hit60_state", 32'(state), 3);
    chk("hit60_show",  32'(show_player), 1);

    tick();
    chk("over_state", 32'(state), 3);
    chk("over_xoff",  32'(x_offset), 322);

    pulse_start();
    chk("restart_state", 32'(state), 1);
    chk("restart_score", 32'(score), 0);
    chk("restart_xoff",  32'(x_offset), 0);
    chk("restart_valid", 32'(obs_valid), 0);

    // Collision in the same cycle as the tick is evaluated on that tick
    @(negedge clk) begin collision = 1'b1; frame_tick = 1'b1; end
    @(negedge clk) begin collision = 1'b0; frame_tick = 1'b0; end
    chk("coll_tick_state", 32'(state), 2);
    chk("coll_tick_xoff",  32'(x_offset), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
